l2spm_req_arbiter: RTL

- Shares the single-ported L2 scratchpad (base 0x1C00_0000, 64 KiB) between the CVA6 cores' memory request ports.
- Arbitrates requests round-robin and range-checks each address against the scratchpad window.
- Tracks outstanding transactions so in-order memory responses are routed back to the correct requester.
- Out-of-range requests are completed locally with an error response and never reach memory.

---
 rtl/l2spm_req_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/l2spm_req_arbiter.sv
// Round-robin arbiter sharing the L2 scratchpad between requesters. Grants take 0 cycles and memory responses are routed back combinationally.
// Out-of-range requests get a local error response 1 cycle later. Requests stall while the outstanding FIFO is full or an error is pending.
module l2spm_req_arbiter #(
  parameter int                NUM_REQ   = 2,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1C00_0000,
  parameter logic [ADDR_W-1:0] LENGTH    = 32'h0001_0000,
  parameter int                MAX_OUTST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0]         req_we_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_be_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]         req_gnt_o,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       mem_req_o,
  input  logic                       mem_gnt_i,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic                       mem_we_o,
  output logic [DATA_W/8-1:0]        mem_be_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  input  logic                       mem_rvalid_i,
  input  logic [DATA_W-1:0]          mem_rdata_i
);
  localparam int BE_W  = DATA_W / 8;
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

  logic [ID_W-1:0]   rr_ptr, winner, err_id;
  logic              any_req, in_range, full, empty, err_pending;
  logic              mem_req, mem_push, err_gnt, pop;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W:0]   addr_off;
  logic              win_we;
  logic [BE_W-1:0]   win_be;
  logic [DATA_W-1:0] win_wdata;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [ID_W-1:0]   fifo_mem [MAX_OUTST];

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req_i[rr_idx(rr_ptr, i)]) begin
        any_req = 1'b1;
        winner  = rr_idx(rr_ptr, i);
      end
    end
  end

  assign win_addr  = req_addr_i[winner*ADDR_W +: ADDR_W];
  assign win_we    = req_we_i[winner];
  assign win_be    = req_be_i[winner*BE_W +: BE_W];
  assign win_wdata = req_wdata_i[winner*DATA_W +: DATA_W];

  // One extra bit keeps windows ending at the top of the address space from wrapping.
  assign addr_off = {1'b0, win_addr} - {1'b0, BASE_ADDR};
  assign in_range = (win_addr >= BASE_ADDR) && (addr_off < {1'b0, LENGTH});

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign mem_req  = any_req && in_range && !full && !err_pending && !rst_i;
  assign mem_push = mem_req && mem_gnt_i;
  assign err_gnt  = any_req && !in_range && empty && !err_pending && !rst_i;
  assign pop      = mem_rvalid_i && !empty;

  always_comb begin
    req_gnt_o   = '0;
    mem_req_o   = mem_req;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_push || err_gnt) req_gnt_o[winner] = 1'b1;
    if (mem_req) begin
      mem_addr_o  = win_addr;
      mem_we_o    = win_we;
      mem_be_o    = win_be;
      mem_wdata_o = win_wdata;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    if (pop) begin
      rsp_valid_o[fifo_mem[head]] = 1'b1;
      rsp_rdata_o                 = mem_rdata_i;
    end else if (err_pending) begin
      rsp_valid_o[err_id] = 1'b1;
      rsp_err_o           = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      err_pending <= 1'b0;
      err_id      <= '0;
    end else begin
      if (mem_push || err_gnt) rr_ptr <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
      if (mem_push) tail <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
      if (pop)      head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
      case ({mem_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      err_pending <= err_gnt;
      if (err_gnt) err_id <= winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_push) fifo_mem[tail] <= winner;
  end

  stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && empty))
    else $warning("mem_rvalid_i with no outstanding request, ignored");

endmodule
